display_ctrl_axil_slave: RTL and testbench
==========================================

# display_ctrl_axil_slave

AXI4-Lite slave register file for the display controller; it is the responder to the AXI4-Lite master that software/VIP uses on the S00_AXI port. It holds four 32-bit read/write registers, implements the write (AW/W/B) and read (AR/R) handshakes with independent per-channel state machines, and presents the register contents plus per-register write pulses to the display datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 5 when DISPCTRL_AXIL_SLVERR_EN is defined
- ACLK  in  1  clock
- ARESET  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data; S_AXI_WSTRB  in  4  byte lanes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  write response; S_AXI_BVALID / S_AXI_BREADY  out / in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID / S_AXI_RREADY  out / in  1
- reg_q  out  128  register contents, reg N at [32N+31:32N]
- reg_wr  out  4  one-cycle pulse, bit N set in the cycle after register N is written

## Operation
- Register index = ADDR[3:2]; ADDR[1:0] ignored. Reset value of all registers 0.
- Write FSM states: W_IDLE (AWREADY=1, WREADY=1), W_HAVE_AW (AWREADY=0, WREADY=1), W_HAVE_W (AWREADY=1, WREADY=0), W_RESP (both 0, BVALID=1).
- W_IDLE: AW and W together -> commit, W_RESP; AW only -> latch address, W_HAVE_AW; W only -> latch data/strobe, W_HAVE_W.
- W_HAVE_AW on WVALID, W_HAVE_W on AWVALID -> commit, W_RESP. W_RESP on BREADY -> W_IDLE.
- Commit: byte lane b of the selected register updated iff WSTRB[b]; WSTRB=0 is a legal no-op write that still responds OKAY and still pulses reg_wr.
- Read FSM states: R_IDLE (ARREADY=1), R_DATA (ARREADY=0, RVALID=1). AR handshake -> RDATA registered from the selected register, R_DATA; RREADY -> R_IDLE.
- RDATA/RRESP held stable while RVALID and not RREADY; BRESP likewise.
- RRESP/BRESP = OKAY (2'b00) for every access unless SLVERR is enabled.
- Read and write channels run concurrently; a read accepted in the same cycle as a commit to the same register returns the old value.

## Timing
- Reset: AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr all 0 while ARESET=1; RDATA, BRESP, RRESP, reg_q = 0. READYs rise in the first cycle after ARESET deasserts.
- Write latency: final of AW/W handshake at edge k -> reg_q updated and BVALID=1 after edge k; reg_wr pulses for exactly the cycle after edge k.
- Back-to-back writes: BREADY held high -> one write per 2 cycles.
- Read latency: AR handshake at edge k -> RVALID=1 with data after edge k; RREADY held high -> one read per 2 cycles.
- ARESET asserted mid-transaction: both FSMs to idle, pending address/data discarded, no B/R response issued, registers cleared.

## Configuration
- DISPCTRL_AXIL_SLVERR_EN defined: C_S_AXI_ADDR_WIDTH=5, 8-word space; ADDR[4]=1 writes are discarded (no reg_wr) with BRESP=SLVERR (2'b10); reads return RDATA=0, RRESP=SLVERR.
- Undefined: ADDR[4] does not exist; all addresses alias onto the four registers, always OKAY.

## Structure
- Package display_ctrl_pkg: AXI response constants (RESP_OKAY, RESP_SLVERR), register count (4), register index constants, write/read FSM state enums.
- Single module; no sub-modules. Byte-lane merge is a function in the package.

## Test plan
- Four writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then four reads -> reads return 0x1..0x4, all RESP OKAY, reg_wr pulses 0001,0010,0100,1000.
- AW two cycles before W, then W two cycles before AW, to 0x4 -> single commit each, BVALID one cycle after later handshake, AWREADY/WREADY per FSM state.
- Write 0xAABBCCDD to 0x8 with WSTRB=4'b0101 over 0x11223344 -> reg 2 reads 0x11BB33DD.
- BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP, RDATA stable; no new AW/W/AR accepted.
- Simultaneous write 0x55 and read of 0xC (old 0x4) -> read returns 0x4, next read 0x55.
- ARESET pulsed while in W_HAVE_AW -> no BVALID, all reg_q=0; with DISPCTRL_AXIL_SLVERR_EN, write to 0x10 -> BRESP=2'b10, registers unchanged.

Source files
------------

// File: rtl/display_ctrl_pkg.sv
// +------------------------------------------------------------------------+
// | display_ctrl_pkg                                                       |
// | Shared constants, FSM state types and byte-lane merge helper for the   |
// | display controller AXI4-Lite register slave.                           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package display_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] REG_IDX_0 = 2'd0;
  localparam logic [1:0] REG_IDX_1 = 2'd1;
  localparam logic [1:0] REG_IDX_2 = 2'd2;
  localparam logic [1:0] REG_IDX_3 = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Replaces only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_ctrl_axil_slave.sv
// +------------------------------------------------------------------------+
// | display_ctrl_axil_slave                                                |
// | AXI4-Lite slave holding four 32-bit display control registers.        |
// | Option macro: DISPCTRL_AXIL_SLVERR_EN (5-bit address, SLVERR on upper  |
// | half of the address space).                                            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module display_ctrl_axil_slave
  import display_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
`ifdef DISPCTRL_AXIL_SLVERR_EN
  parameter int C_S_AXI_ADDR_WIDTH = 5
`else
  parameter int C_S_AXI_ADDR_WIDTH = 4
`endif
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [3:0]                         S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                reg_wr
);

  wr_state_e r_wstate, w_wstate_nxt;
  rd_state_e r_rstate, w_rstate_nxt;

  logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0] r_bresp, r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [NUM_REGS-1:0] r_reg_wr;
  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] r_regs;

  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [3:0]                    r_wstrb;

  logic w_aw_hs, w_w_hs, w_ar_hs;
  logic w_commit, w_aw_latch, w_w_latch;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_cm_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_cm_data;
  logic [3:0]                    w_cm_strb;
  logic [1:0] w_cm_idx, w_rd_idx;
  logic w_cm_err, w_rd_err;
  logic w_unused;

  assign w_aw_hs = r_awready & S_AXI_AWVALID;
  assign w_w_hs  = r_wready  & S_AXI_WVALID;
  assign w_ar_hs = r_arready & S_AXI_ARVALID;

  assign w_cm_idx = w_cm_addr[3:2];
  assign w_rd_idx = S_AXI_ARADDR[3:2];

`ifdef DISPCTRL_AXIL_SLVERR_EN
  assign w_cm_err = w_cm_addr[4];
  assign w_rd_err = S_AXI_ARADDR[4];
`else
  assign w_cm_err = 1'b0;
  assign w_rd_err = 1'b0;
`endif

  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], w_cm_addr[1:0]};

  // Commit operands come from the live bus or the half latched earlier.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    w_aw_latch   = 1'b0;
    w_w_latch    = 1'b0;
    w_cm_addr    = S_AXI_AWADDR;
    w_cm_data    = S_AXI_WDATA;
    w_cm_strb    = S_AXI_WSTRB;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_aw_latch   = 1'b1;
          w_wstate_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_w_latch    = 1'b1;
          w_wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        w_cm_addr = r_awaddr;
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_HAVE_W: begin
        w_cm_data = r_wdata;
        w_cm_strb = r_wstrb;
        if (w_aw_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they stay low during reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_rstate  <= w_rstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_W);
      r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_AW);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_regs   <= '0;
      r_reg_wr <= '0;
      r_bresp  <= RESP_OKAY;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_reg_wr <= '0;
      if (w_aw_latch) r_awaddr <= S_AXI_AWADDR;
      if (w_w_latch) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bresp <= w_cm_err ? RESP_SLVERR : RESP_OKAY;
        if (!w_cm_err) begin
          r_regs[w_cm_idx]   <= merge_bytes(r_regs[w_cm_idx], w_cm_data, w_cm_strb);
          r_reg_wr[w_cm_idx] <= 1'b1;
        end
      end
      // Same-edge commit is not visible here, so a colliding read sees the old value.
      if (w_ar_hs) begin
        r_rdata <= w_rd_err ? '0 : r_regs[w_rd_idx];
        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_q         = r_regs;
  assign reg_wr        = r_reg_wr;

endmodule

`default_nettype wire

// File: tb/tb_display_ctrl_axil_slave.sv
// +------------------------------------------------------------------------+
// | tb_display_ctrl_axil_slave                                             |
// | Directed self-checking bench for display_ctrl_axil_slave.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_display_ctrl_axil_slave;

`ifdef DISPCTRL_AXIL_SLVERR_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [127:0]  reg_q;
  logic [3:0]    reg_wr;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  display_ctrl_axil_slave dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input bit need_aw, input bit need_w, input bit need_ar);
    int k;
    k = 0;
    while (((need_aw && !awready) || (need_w && !wready) || (need_ar && !arready)) && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    assert (k < 20) else begin
      n_mis++;
      $error("FAIL %s: ready wait observed %0d cycles, limit 20", tag, k);
    end
  endtask

  task automatic axil_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp, input logic [3:0] exp_wr);
    awaddr = a[AW-1:0]; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_ready(tag, 1'b1, 1'b1, 1'b0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, " bvalid"}, bvalid, 1'b1);
    chk({tag, " bresp"}, bresp, exp_resp);
    chk({tag, " reg_wr"}, reg_wr, exp_wr);
    tick();
    chk({tag, " bvalid drop"}, bvalid, 1'b0);
    chk({tag, " reg_wr drop"}, reg_wr, 4'b0000);
  endtask

  task automatic axil_read(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp);
    araddr = a[AW-1:0];
    arvalid = 1'b1;
    wait_ready(tag, 1'b0, 1'b0, 1'b1);
    tick();
    arvalid = 1'b0;
    chk({tag, " rvalid"}, rvalid, 1'b1);
    chk({tag, " rdata"}, rdata, exp_d);
    chk({tag, " rresp"}, rresp, exp_resp);
    tick();
    chk({tag, " rvalid drop"}, rvalid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst readies", {awready, wready, arready}, 3'b000);
    chk("rst valids", {bvalid, rvalid}, 2'b00);
    chk("rst reg_wr", reg_wr, 4'b0000);
    chk("rst reg_q", reg_q, 128'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst resps", {bresp, rresp}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("post-rst readies", {awready, wready, arready}, 3'b111);

    // Four writes and read-back
    axil_write("wr0", 8'h0, 32'h1, 4'hF, 2'b00, 4'b0001);
    axil_write("wr1", 8'h4, 32'h2, 4'hF, 2'b00, 4'b0010);
    axil_write("wr2", 8'h8, 32'h3, 4'hF, 2'b00, 4'b0100);
    axil_write("wr3", 8'hC, 32'h4, 4'hF, 2'b00, 4'b1000);
    chk("reg_q after 4 writes", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});
    axil_read("rd0", 8'h0, 32'h1, 2'b00);
    axil_read("rd1", 8'h4, 32'h2, 2'b00);
    axil_read("rd2", 8'h8, 32'h3, 2'b00);
    axil_read("rd3", 8'hC, 32'h4, 2'b00);

    // AW two cycles ahead of W
    awaddr = 4'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("have_aw readies", {awready, wready, bvalid}, 3'b010);
    tick();
    chk("have_aw hold", {awready, wready, bvalid}, 3'b010);
    wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("aw-first resp", {awready, wready, bvalid}, 3'b001);
    chk("aw-first reg_wr", reg_wr, 4'b0010);
    chk("aw-first reg1", reg_q[63:32], 32'hA5A5_0001);
    tick();
    chk("aw-first done", {bvalid, reg_wr}, 5'b0);

    // W two cycles ahead of AW
    wdata = 32'h5A5A_0002; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("have_w readies", {awready, wready, bvalid}, 3'b100);
    tick();
    chk("have_w hold", {awready, wready, bvalid}, 3'b100);
    awaddr = 4'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("w-first resp", {awready, wready, bvalid}, 3'b001);
    chk("w-first reg_wr", reg_wr, 4'b0010);
    chk("w-first reg1", reg_q[63:32], 32'h5A5A_0002);
    tick();

    // Byte strobes, including the empty strobe
    axil_write("strb full", 8'h8, 32'h1122_3344, 4'hF, 2'b00, 4'b0100);
    axil_write("strb 0101", 8'h8, 32'hAABB_CCDD, 4'b0101, 2'b00, 4'b0100);
    axil_read("strb rd", 8'h8, 32'h11BB_33DD, 2'b00);
    axil_write("strb none", 8'h8, 32'hFFFF_FFFF, 4'b0000, 2'b00, 4'b0100);
    axil_read("strb none rd", 8'h8, 32'h11BB_33DD, 2'b00);

    // Back-pressure on B and R
    bready = 1'b0; rready = 1'b0;
    araddr = 4'h8; arvalid = 1'b1;
    wait_ready("stall ar", 1'b0, 1'b0, 1'b1);
    tick();
    arvalid = 1'b0;
    awaddr = 4'h0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_ready("stall aw", 1'b1, 1'b1, 1'b0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    awaddr = 4'hC; wdata = 32'h99; araddr = 4'h0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall valids", {bvalid, rvalid}, 2'b11);
      chk("stall resps", {bresp, rresp}, 4'b0000);
      chk("stall rdata", rdata, 32'h11BB_33DD);
      chk("stall readies", {awready, wready, arready}, 3'b000);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("stall release", {bvalid, rvalid}, 2'b00);
    chk("stall reg0", reg_q[31:0], 32'hDEAD_BEEF);
    chk("stall reg3 untouched", reg_q[127:96], 32'h4);

    // Simultaneous write and read of the same register
    awaddr = 4'hC; araddr = 4'hC; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_ready("collide", 1'b1, 1'b1, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("collide valids", {bvalid, rvalid}, 2'b11);
    chk("collide old rdata", rdata, 32'h4);
    chk("collide reg3", reg_q[127:96], 32'h55);
    chk("collide reg_wr", reg_wr, 4'b1000);
    tick();
    axil_read("collide next", 8'hC, 32'h55, 2'b00);

    // Reset in the middle of a write
    awaddr = 4'h4; awvalid = 1'b1;
    wait_ready("mid-rst aw", 1'b1, 1'b0, 1'b0);
    tick();
    awvalid = 1'b0;
    chk("mid-rst have_aw", {awready, wready}, 2'b01);
    rst = 1'b1;
    tick();
    chk("mid-rst reg_q", reg_q, 128'h0);
    chk("mid-rst outputs", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    rst = 1'b0;
    tick();
    chk("mid-rst idle", {awready, wready, arready, bvalid}, 4'b1110);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("mid-rst aw discarded", {awready, wready, bvalid}, 3'b100);
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid-rst commit bvalid", bvalid, 1'b1);
    chk("mid-rst commit reg_wr", reg_wr, 4'b0100);
    tick();
    chk("mid-rst reg_q", reg_q, {32'h0, 32'h1234_5678, 32'h0, 32'h0});

    // Low address bits ignored
    axil_write("alias wr", 8'h7, 32'h77, 4'hF, 2'b00, 4'b0010);
    axil_read("alias rd", 8'h4, 32'h77, 2'b00);

`ifdef DISPCTRL_AXIL_SLVERR_EN
    axil_write("slverr wr", 8'h10, 32'h0BAD, 4'hF, 2'b10, 4'b0000);
    chk("slverr reg_q", reg_q, {32'h0, 32'h1234_5678, 32'h77, 32'h0});
    axil_read("slverr rd", 8'h14, 32'h0, 2'b10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
